// File: rtl/byte_serial_add_ctrl_pkg.sv
// Shared definitions for the byte-serial add sequencer.
//   state_t        : sequencer states (IDLE, RUN, DONE)
//   BYTE_W         : width of one adder slice (8)
//   NBYTES_DEFAULT : default operand width in bytes
//   byte_lo()      : bit index of the LSB of byte k in a wide word
package byte_serial_add_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int BYTE_W         = 8;
  localparam int NBYTES_DEFAULT = 4;

  // Byte k occupies bits [byte_lo(k) +: BYTE_W] of a wide operand.
  function automatic int byte_lo(input int k);
    return k * BYTE_W;
  endfunction

endpackage

// File: rtl/byte_serial_add_ctrl.sv
// Multi-byte adder sequencer: feeds one byte per clock to an external
// 8-bit ripple-carry adder and assembles the wide result.
// Ports:
//   clk, rst_n          clock (rising) / async active-low reset
//   start               request, sampled only in IDLE
//   op_a, op_b, cin     operands and initial carry (latched on accept)
//   add_a, add_b        byte to adder, index 0 = LSB (0 outside RUN)
//   add_cin             carry to adder (0 outside RUN)
//   add_s, add_cout     adder sum (index 0 = LSB) and carry-out
//   sum, cout, ovf      result, final carry, signed overflow (held)
//   busy                high in RUN and DONE
//   done                one-cycle pulse in DONE
// Handshake: start is accepted on the rising edge where the block is IDLE
// and start=1; the result is valid from the done cycle on and stays until
// the next accepted start. start outside IDLE is ignored (no queueing).
module byte_serial_add_ctrl
  import byte_serial_add_ctrl_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [BYTE_W*NBYTES-1:0]   op_a,
  input  logic [BYTE_W*NBYTES-1:0]   op_b,
  input  logic                       cin,
  output logic [0:BYTE_W-1]          add_a,
  output logic [0:BYTE_W-1]          add_b,
  output logic                       add_cin,
  input  logic [0:BYTE_W-1]          add_s,
  input  logic                       add_cout,
  output logic [BYTE_W*NBYTES-1:0]   sum,
  output logic                       cout,
  output logic                       ovf,
  output logic                       busy,
  output logic                       done
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int KW = $clog2(NBYTES);

  state_t          state_r, state_nx;
  logic [KW-1:0]   k_r;
  logic            carry_r;
  logic [W-1:0]    a_lat, b_lat;
  logic [W-1:0]    sum_r;
  logic            cout_r, ovf_r;

  logic            last_byte;
  logic [W-1:0]    a_sh, b_sh;
  logic [7:0]      s_byte;
  logic [W-1:0]    sum_nx;
  int              lo;

  assign last_byte = (k_r == KW'(NBYTES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_byte) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Byte selection and sum merge. The adder ports are bit-ascending
  // ([0:7], index 0 = LSB) so bytes are copied bit by bit rather than by
  // vector assignment, which would reverse the significance.
  always_comb begin
    lo   = byte_lo(int'(k_r));
    a_sh = a_lat >> lo;
    b_sh = b_lat >> lo;
    for (int i = 0; i < BYTE_W; i++) s_byte[i] = add_s[i];
    sum_nx = (sum_r & ~({{(W-8){1'b0}}, 8'hFF} << lo)) |
             ({{(W-8){1'b0}}, s_byte} << lo);
  end

  // Output logic
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    busy    = (state_r != IDLE);
    done    = (state_r == DONE);
    if (state_r == RUN) begin
      for (int i = 0; i < BYTE_W; i++) begin
        add_a[i] = a_sh[i];
        add_b[i] = b_sh[i];
      end
      add_cin = carry_r;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r     <= '0;
      carry_r <= 1'b0;
      a_lat   <= '0;
      b_lat   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_lat   <= op_a;
            b_lat   <= op_b;
            carry_r <= cin;
            k_r     <= '0;
          end
        end
        RUN: begin
          sum_r   <= sum_nx;
          carry_r <= add_cout;
          k_r     <= k_r + KW'(1);
          // Final byte: its sum MSB is the result MSB, so overflow can be
          // decided here and presented together with cout in DONE.
          if (last_byte) begin
            cout_r <= add_cout;
            ovf_r  <= (a_lat[W-1] == b_lat[W-1]) && (add_s[BYTE_W-1] != a_lat[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
module tb_byte_serial_add_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cin = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [0:7]    add_a, add_b, add_s;
  logic          add_cin, add_cout;
  logic [W-1:0]  sum;
  logic          cout, ovf, busy, done;
  logic          rc;

  // ---------------- clock / reset / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  byte_serial_add_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy), .done(done)
  );

  // 8-bit ripple-carry adder beside the block (index 0 = LSB).
  always_comb begin
    rc = add_cin;
    add_s = '0;
    for (int i = 0; i < 8; i++) begin
      add_s[i] = add_a[i] ^ add_b[i] ^ rc;
      rc = (add_a[i] & add_b[i]) | (rc & (add_a[i] ^ add_b[i]));
    end
    add_cout = rc;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_fl_q[$];   // {cout, ovf}
  int           exp_cyc_q[$];  // cycle count at which done must be seen
  logic [W-1:0] last_sum;
  logic         last_cout, last_ovf;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int e0);
    logic [W:0] full;
    logic       v;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    v = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    exp_q.push_back(full[W-1:0]);
    exp_fl_q.push_back({full[W], v});
    exp_cyc_q.push_back(e0 + NB);
    last_sum  = full[W-1:0];
    last_cout = full[W];
    last_ovf  = v;
  endtask

  always @(negedge clk) begin
    logic [W-1:0] s;
    logic [1:0]   fl;
    int           ec;
    if (rst_n && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        s  = exp_q.pop_front();
        fl = exp_fl_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("sum", 64'(sum), 64'(s));
        check("cout", 64'(cout), 64'(fl[1]));
        check("ovf", 64'(ovf), 64'(fl[0]));
        check("done_latency", 64'(cyc), 64'(ec));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit push, input bit scramble);
    @(negedge clk);
    op_a = a; op_b = b; cin = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) push_exp(a, b, c, cyc);
    if (scramble) begin
      op_a = ~a; op_b = a ^ b ^ 32'h5A5A_A5A5; cin = ~c;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
    exp_q.delete(); exp_fl_q.delete(); exp_cyc_q.delete();
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    start_op(a, b, c, 1'b1, 1'b0);
    wait_drain();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    repeat (3) @(negedge clk);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_add_a", 64'(add_a), 64'd0);
    check("rst_add_b", 64'(add_b), 64'd0);
    check("rst_add_cin", 64'(add_cin), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte carry into byte 1
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
    // Result holds in IDLE, adder inputs parked at 0
    repeat (3) @(negedge clk);
    check("hold_sum", 64'(sum), 64'(last_sum));
    check("hold_cout", 64'(cout), 64'(last_cout));
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_add_a", 64'(add_a), 64'd0);

    // Carry ripples through all bytes
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    // Signed overflow via cin
    do_op(32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    repeat (2) @(negedge clk);
    check("hold_ovf", 64'(ovf), 64'(last_ovf));

    // Random operands
    for (int i = 0; i < 4; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    // Operands changed right after the start edge
    start_op(32'h0123_4567, 32'h89AB_CDEF, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // start held for 20 edges: one accept every NB+2 cycles
    @(negedge clk);
    op_a = 32'd1; op_b = 32'd2; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    c0 = cyc;
    for (int j = 0; j < 4; j++) push_exp(32'd1, 32'd2, 1'b0, c0 + j * (NB + 2));
    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      check("busy_held", 64'(busy), 64'(((cyc - c0) % (NB + 2)) <= NB));
      if (t == 19) start = 1'b0;
    end
    wait_drain();

    // Leave ovf=1 so the abort clears something visible
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);

    // Abort mid-run after byte 1 captured
    start_op(32'hAAAA_AAAA, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("partial_bytes", 64'(sum[15:0]), 64'h0000_BBBB);
    rst_n = 1'b0;
    #1;
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_ovf", 64'(ovf), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_add_a", 64'(add_a), 64'd0);
    check("abort_add_cin", 64'(add_cin), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0);
    check("restart_sum", 64'(sum), 64'h2345_6789);
    check("restart_cout", 64'(cout), 64'd0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
